// File: rtl/distortion_scale_ctrl.sv
// Per-point coordinate scaler: x*Xn/Xd then y*Yn/Yd on one shared restoring divider,
// plus the frame-synchronous distortion_mode that selects the upstream factor switch.
module distortion_scale_ctrl #(
  parameter int CW = 11,
  parameter int FW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          mode_req,
  output logic          distortion_mode,
  input  logic [FW-1:0] Xnumer,
  input  logic [FW-1:0] Xdenom,
  input  logic [FW-1:0] Ynumer,
  input  logic [FW-1:0] Ydenom,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] x_in,
  input  logic [CW-1:0] y_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] x_out,
  output logic [CW-1:0] y_out,
  output logic          busy,
  output logic          div0_err
);
  localparam int N    = CW + FW;
  localparam int CNTW = $clog2(N);

  typedef enum logic [1:0] {IDLE, DIVX, DIVY, OUT} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]   y_q, y_d, xo_q, xo_d, yo_q, yo_d;
  logic [FW-1:0]   yn_q, yn_d, yd_q, yd_d, div_q, div_d, rem_q, rem_d;
  logic [N-1:0]    quo_q, quo_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            mode_q, mode_d, pend_q, pend_d, pval_q, pval_d, err_q, err_d;

  logic [FW:0]     rem_sh, diff;
  logic            ge, err_set, last;
  logic [N-1:0]    quo_nx;
  logic [FW-1:0]   rem_nx;
  logic [CW-1:0]   res;

  // quo_q holds the not-yet-consumed dividend bits and shifts quotient bits in from the right
  always_comb begin
    rem_sh = {rem_q, quo_q[N-1]};
    diff   = rem_sh - {1'b0, div_q};
    ge     = rem_sh >= {1'b0, div_q};
    quo_nx = {quo_q[N-2:0], ge};
    rem_nx = ge ? diff[FW-1:0] : rem_sh[FW-1:0];
    res    = (div_q == '0 || |quo_nx[N-1:CW]) ? '1 : quo_nx[CW-1:0];
    last   = cnt_q == CNTW'(N-1);
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    yn_d    = yn_q;
    yd_d    = yd_q;
    div_d   = div_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    mode_d  = mode_q;
    pend_d  = pend_q;
    pval_d  = pval_q;
    err_set = 1'b0;
    unique case (state_q)
      IDLE: if (in_valid) begin
        state_d = DIVX;
        y_d     = y_in;
        yn_d    = Ynumer;
        yd_d    = Ydenom;
        div_d   = Xdenom;
        rem_d   = '0;
        quo_d   = N'(x_in) * N'(Xnumer);
        cnt_d   = '0;
      end
      DIVX, DIVY: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + CNTW'(1);
        if (last) begin
          cnt_d   = '0;
          err_set = div_q == '0;
          if (state_q == DIVX) begin
            xo_d    = res;
            state_d = DIVY;
            div_d   = yd_q;
            rem_d   = '0;
            quo_d   = N'(y_q) * N'(yn_q);
          end else begin
            yo_d    = res;
            state_d = OUT;
          end
        end
      end
      OUT: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Mode may only move on entry to (or while sitting in) IDLE; otherwise it is parked.
    if (frame_start) begin
      if (state_q == IDLE && !in_valid) begin
        mode_d = mode_req;
        pend_d = 1'b0;
      end else begin
        pend_d = 1'b1;
        pval_d = mode_req;
      end
    end
    if (state_q == OUT && out_ready) begin
      if (frame_start)  mode_d = mode_req;
      else if (pend_q)  mode_d = pval_q;
      pend_d = 1'b0;
    end
    err_d = (err_q & ~frame_start) | err_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      y_q     <= '0;
      yn_q    <= '0;
      yd_q    <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      mode_q  <= 1'b0;
      pend_q  <= 1'b0;
      pval_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      yn_q    <= yn_d;
      yd_q    <= yd_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      pval_q  <= pval_d;
      err_q   <= err_d;
    end
  end

  assign in_ready        = state_q == IDLE;
  assign out_valid       = state_q == OUT;
  assign busy            = state_q != IDLE;
  assign x_out           = xo_q;
  assign y_out           = yo_q;
  assign distortion_mode = mode_q;
  assign div0_err        = err_q;
endmodule

// File: tb/tb_distortion_scale_ctrl.sv
// Directed bench for distortion_scale_ctrl: arithmetic model + result queue checked every cycle,
// with literal expectations for latency, saturation, div0, backpressure, mode and reset.
module tb_distortion_scale_ctrl;
  localparam int CW   = 11;
  localparam int FW   = 7;
  localparam int MAXV = (1 << CW) - 1;

  logic clk = 0, reset = 0, frame_start = 0, mode_req = 0;
  logic distortion_mode, in_ready, out_valid, busy, div0_err;
  logic in_valid = 0, out_ready = 1;
  logic [FW-1:0] Xnumer = 0, Xdenom = 0, Ynumer = 0, Ydenom = 0;
  logic [CW-1:0] x_in = 0, y_in = 0, x_out, y_out;

  int checks = 0, failures = 0;

  typedef struct { int unsigned x; int unsigned y; } res_t;
  res_t exp_q[$];

  distortion_scale_ctrl #(.CW(CW), .FW(FW)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .mode_req(mode_req),
    .distortion_mode(distortion_mode), .Xnumer(Xnumer), .Xdenom(Xdenom),
    .Ynumer(Ynumer), .Ydenom(Ydenom), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .busy(busy), .div0_err(div0_err));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // coord*numer/denom, truncated, saturated; zero denominator gives full scale
  function automatic int unsigned scale(input int unsigned c, input int unsigned n, input int unsigned d);
    int unsigned q;
    if (d == 0) return MAXV;
    q = (c * n) / d;
    return (q > MAXV) ? MAXV : q;
  endfunction

  // Inputs change #1 after posedge, so negedge sees what the next posedge will sample.
  always @(negedge clk) begin
    if (reset) exp_q.delete();
    else begin
      if (out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else begin
          chk("model_x_out", x_out, exp_q[0].x);
          chk("model_y_out", y_out, exp_q[0].y);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back('{scale(x_in, Xnumer, Xdenom), scale(y_in, Ynumer, Ydenom)});
    end
  end

  task automatic drive(input int x, input int xn, input int xd, input int y, input int yn, input int yd);
    x_in = CW'(x); Xnumer = FW'(xn); Xdenom = FW'(xd);
    y_in = CW'(y); Ynumer = FW'(yn); Ydenom = FW'(yd);
  endtask

  // Presents one point while in IDLE; returns after the accepting edge (+1).
  task automatic accept_pt(input int x, input int xn, input int xd, input int y, input int yn, input int yd);
    drive(x, xn, xd, y, yn, yd);
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    drive(0, 1, 1, 0, 1, 1);
  endtask

  // Edges counted with the accepting edge as edge 1; returns at the edge out_valid is first seen.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) chk("timeout_out_valid", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("timeout_idle", 0, 1);
  endtask

  initial begin
    int lat;
    int ta[2];
    int acc;

    // reset values
    #1 reset = 1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_x_out", x_out, 0);
    chk("rst_mode", distortion_mode, 0);
    chk("rst_div0", div0_err, 0);
    @(posedge clk); @(posedge clk); #1 reset = 0;

    // model pins
    chk("pin_scale_half", scale(100, 40, 80), 50);
    chk("pin_scale_trunc", scale(101, 40, 80), 50);
    chk("pin_scale_sat", scale(2047, 127, 1), MAXV);
    chk("pin_scale_div0", scale(5, 40, 0), MAXV);

    // 1) basic point and latency
    accept_pt(100, 40, 80, 200, 32, 64);
    wait_out(lat);
    chk("t1_latency", lat, 37);
    chk("t1_x_out", x_out, 50);
    chk("t1_y_out", y_out, 100);
    chk("t1_in_ready_out", in_ready, 0);
    @(posedge clk); #1;
    chk("t1_back_idle", in_ready, 1);

    // 2) truncation and saturation
    accept_pt(101, 40, 80, 7, 3, 2);
    wait_out(lat);
    chk("t2_trunc_x", x_out, 50);
    chk("t2_y", y_out, 10);
    @(posedge clk); #1;
    accept_pt(2047, 127, 1, 1000, 127, 3);
    wait_out(lat);
    chk("t2_sat_x", x_out, MAXV);
    chk("t2_sat_y", y_out, MAXV);
    @(posedge clk); #1;

    // 3) zero denominator
    chk("t3_div0_before", div0_err, 0);
    accept_pt(5, 40, 0, 9, 2, 3);
    wait_out(lat);
    chk("t3_div0_lat", lat, 37);
    chk("t3_x_div0", x_out, MAXV);
    chk("t3_y_ok", y_out, 6);
    chk("t3_div0_set", div0_err, 1);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1 chk("t3_div0_held", div0_err, 1);
    frame_start = 1; mode_req = 0;
    @(posedge clk); #1 frame_start = 0;
    chk("t3_div0_clr", div0_err, 0);

    // 4) backpressure
    out_ready = 0;
    accept_pt(60, 40, 80, 90, 32, 64);
    wait_out(lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("t4_out_valid_hold", out_valid, 1);
      chk("t4_in_ready_low", in_ready, 0);
      chk("t4_x_hold", x_out, 30);
      chk("t4_y_hold", y_out, 45);
    end
    out_ready = 1;
    @(posedge clk); #1;
    chk("t4_idle_after", in_ready, 1);
    chk("t4_out_valid_drop", out_valid, 0);

    // throughput with in_valid and out_ready held high
    drive(10, 2, 1, 20, 1, 2);
    in_valid = 1; acc = 0;
    for (int e = 0; e < 200 && acc < 2; e++) begin
      if (in_ready) begin ta[acc] = e; acc++; end
      @(posedge clk); #1;
    end
    in_valid = 0;
    chk("tput_accepts", acc, 2);
    chk("tput_period", ta[1] - ta[0], 38);
    wait_idle();

    // 5) mode change parked while busy
    accept_pt(8, 1, 1, 8, 1, 1);
    @(posedge clk); #1;
    frame_start = 1; mode_req = 1;
    @(posedge clk); #1 frame_start = 0; mode_req = 0;
    chk("t5_mode_busy", distortion_mode, 0);
    wait_out(lat);
    chk("t5_mode_at_out", distortion_mode, 0);
    @(posedge clk); #1;
    chk("t5_mode_idle", distortion_mode, 1);
    frame_start = 1; mode_req = 0;
    @(posedge clk); #1 frame_start = 0;
    chk("t5_mode_idle_upd", distortion_mode, 0);
    // frame_start coinciding with the accepting handshake is parked too
    drive(4, 3, 2, 4, 1, 4);
    in_valid = 1; frame_start = 1; mode_req = 1;
    @(posedge clk); #1 in_valid = 0; frame_start = 0; mode_req = 0;
    chk("t5_mode_hs_park", distortion_mode, 0);
    wait_out(lat);
    chk("t5_mode_hs_out", distortion_mode, 0);
    @(posedge clk); #1;
    chk("t5_mode_hs_idle", distortion_mode, 1);

    // 6) asynchronous reset during DIVY
    accept_pt(300, 40, 80, 50, 5, 7);
    repeat (25) @(posedge clk);
    #3 reset = 1;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_busy", busy, 0);
    chk("t6_x_out", x_out, 0);
    chk("t6_y_out", y_out, 0);
    chk("t6_mode", distortion_mode, 0);
    @(posedge clk); #1 reset = 0;
    accept_pt(100, 40, 80, 200, 32, 64);
    wait_out(lat);
    chk("t6_post_lat", lat, 37);
    chk("t6_post_x", x_out, 50);
    chk("t6_post_y", y_out, 100);
    @(posedge clk); #1;
    chk("t6_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
